// File: rtl/step_pkg.sv
// Shared encodings for the curtain stepper driver: coil phases, bus commands
// and the controller state enum.
package step_pkg;

  localparam logic [3:0] PHASE_0 = 4'b1000;
  localparam logic [3:0] PHASE_1 = 4'b0100;
  localparam logic [3:0] PHASE_2 = 4'b0010;
  localparam logic [3:0] PHASE_3 = 4'b0001;

  localparam logic [3:0] CMD_STOP    = 4'b0000;
  localparam logic [3:0] CMD_RUN_FWD = 4'b1000;
  localparam logic [3:0] CMD_JOG_FWD = 4'b0100;
  localparam logic [3:0] CMD_JOG_REV = 4'b0010;
  localparam logic [3:0] CMD_RUN_REV = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_FWD,
    ST_RUN_REV,
    ST_JOG,
    ST_DEAD
  } state_t;

  function automatic logic [3:0] phase_of(input logic [1:0] idx);
    logic [3:0] p;
    case (idx)
      2'd0:    p = PHASE_0;
      2'd1:    p = PHASE_1;
      2'd2:    p = PHASE_2;
      default: p = PHASE_3;
    endcase
    return p;
  endfunction

  function automatic logic cmd_legal(input logic [3:0] c);
    return (c == CMD_STOP) || (c == CMD_RUN_FWD) || (c == CMD_RUN_REV) ||
           (c == CMD_JOG_FWD) || (c == CMD_JOG_REV);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step-period prescaler: down-counter reloaded on clear or terminal count,
// producing a one-cycle tick every STEP_DIV enabled cycles.
module step_timer #(
  parameter int STEP_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/step_driver.sv
// Curtain stepper phase driver: decodes the bus command, paces steps from
// step_timer, sequences full-step coil phases and tracks position.
//
// state   | meaning
// IDLE    | no motion; coil held (HOLD=1) or released
// RUN_FWD | stepping toward open on every tick
// RUN_REV | stepping toward closed on every tick
// JOG     | one step at the first tick, then IDLE
// DEAD    | one idle step period between opposite run directions
module step_driver
  import step_pkg::*;
#(
  parameter int STEP_DIV = 50000,
  parameter int POS_MAX  = 2000,
  parameter int HOLD     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bus,
  output logic [3:0]  coil,
  output logic [15:0] pos,
  output logic        busy,
  output logic        at_open,
  output logic        at_closed,
  output logic        cmd_err
);

  localparam logic [15:0] POS_MAX_W = 16'(POS_MAX);
  localparam bit          HOLD_B    = (HOLD != 0);

  state_t      state;
  logic [1:0]  idx;
  logic [3:0]  prev_cmd;
  logic        dead_fwd;
  logic        jog_fwd;

  logic        legal;
  logic [3:0]  cmd;
  logic        tick;
  logic        at_max;
  logic        at_min;
  logic        step_req;
  logic        step_fwd;
  logic [1:0]  idx_step;
  logic [15:0] pos_step;
  logic        landing;

  assign legal  = cmd_legal(bus);
  assign cmd    = legal ? bus : CMD_STOP;
  assign at_max = (pos == POS_MAX_W);
  assign at_min = (pos == 16'd0);
  assign busy   = (state != ST_IDLE);

  step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_IDLE),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  // A step is only ever requested when it stays inside [0, POS_MAX].
  always_comb begin
    step_req = 1'b0;
    step_fwd = 1'b0;
    if (tick) begin
      case (state)
        ST_RUN_FWD: begin
          step_req = (cmd == CMD_RUN_FWD) && !at_max;
          step_fwd = 1'b1;
        end
        ST_RUN_REV: step_req = (cmd == CMD_RUN_REV) && !at_min;
        ST_JOG: begin
          step_req = jog_fwd ? !at_max : !at_min;
          step_fwd = jog_fwd;
        end
        default: ;
      endcase
    end
  end

  assign idx_step = step_fwd ? idx + 2'd1 : idx - 2'd1;
  assign pos_step = step_fwd ? pos + 16'd1 : pos - 16'd1;
  assign landing  = step_fwd ? (pos_step == POS_MAX_W) : (pos_step == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      coil      <= 4'b0000;
      idx       <= 2'd0;
      pos       <= 16'd0;
      at_open   <= 1'b0;
      at_closed <= 1'b1;
      cmd_err   <= 1'b0;
      prev_cmd  <= CMD_STOP;
      dead_fwd  <= 1'b0;
      jog_fwd   <= 1'b0;
    end else begin
      cmd_err  <= !legal;
      prev_cmd <= cmd;

      if (step_req) begin
        idx       <= idx_step;
        pos       <= pos_step;
        coil      <= phase_of(idx_step);
        at_open   <= (pos_step == POS_MAX_W);
        at_closed <= (pos_step == 16'd0);
      end

      // Transitions into IDLE come last so the release of the coil overrides
      // the pattern of a landing step when HOLD is off.
      case (state)
        ST_IDLE: begin
          if (cmd == CMD_RUN_FWD && !at_max) begin
            state <= ST_RUN_FWD;
          end else if (cmd == CMD_RUN_REV && !at_min) begin
            state <= ST_RUN_REV;
          end else if (cmd == CMD_JOG_FWD && prev_cmd == CMD_STOP && !at_max) begin
            state   <= ST_JOG;
            jog_fwd <= 1'b1;
          end else if (cmd == CMD_JOG_REV && prev_cmd == CMD_STOP && !at_min) begin
            state   <= ST_JOG;
            jog_fwd <= 1'b0;
          end
        end
        ST_RUN_FWD: begin
          if (tick) begin
            if (step_req) begin
              if (landing) begin
                state <= ST_IDLE;
                if (!HOLD_B) coil <= 4'b0000;
              end
            end else if (cmd == CMD_RUN_REV) begin
              state    <= ST_DEAD;
              dead_fwd <= 1'b0;
            end else begin
              state <= ST_IDLE;
              if (!HOLD_B) coil <= 4'b0000;
            end
          end
        end
        ST_RUN_REV: begin
          if (tick) begin
            if (step_req) begin
              if (landing) begin
                state <= ST_IDLE;
                if (!HOLD_B) coil <= 4'b0000;
              end
            end else if (cmd == CMD_RUN_FWD) begin
              state    <= ST_DEAD;
              dead_fwd <= 1'b1;
            end else begin
              state <= ST_IDLE;
              if (!HOLD_B) coil <= 4'b0000;
            end
          end
        end
        ST_JOG: begin
          if (tick) begin
            state <= ST_IDLE;
            if (!HOLD_B) coil <= 4'b0000;
          end
        end
        ST_DEAD: begin
          if (tick) begin
            if (dead_fwd && cmd == CMD_RUN_FWD && !at_max) begin
              state <= ST_RUN_FWD;
            end else if (!dead_fwd && cmd == CMD_RUN_REV && !at_min) begin
              state <= ST_RUN_REV;
            end else begin
              state <= ST_IDLE;
              if (!HOLD_B) coil <= 4'b0000;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_driver.sv
// Directed bench for step_driver (STEP_DIV=4, POS_MAX=6, HOLD=1): stimulus
// queues expected steps with their edge number, a monitor checks each step.
module tb_step_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  bus = 4'b0000;
  logic [3:0]  coil;
  logic [15:0] pos;
  logic        busy;
  logic        at_open;
  logic        at_closed;
  logic        cmd_err;

  step_driver #(.STEP_DIV(4), .POS_MAX(6), .HOLD(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .coil      (coil),
    .pos       (pos),
    .busy      (busy),
    .at_open   (at_open),
    .at_closed (at_closed),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge N, cyc == N until the next rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  coil;
    logic [15:0] pos;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [15:0] p, input int at_cyc);
    exp_t e;
    e.coil = c;
    e.pos  = p;
    e.cyc  = at_cyc;
    sb.push_back(e);
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: any change of coil or pos outside reset is a step to be scored.
  logic [3:0]  prev_coil = 4'b0000;
  logic [15:0] prev_pos  = 16'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_coil = coil;
      prev_pos  = pos;
    end else if (coil !== prev_coil || pos !== prev_pos) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_step: coil=%b pos=%0d at cyc %0d, none expected", coil, pos, cyc);
      end else begin
        e = sb.pop_front();
        check("step_coil", 32'(coil), 32'(e.coil));
        check("step_pos", 32'(pos), 32'(e.pos));
        check("step_at_open", 32'(at_open), 32'(e.pos == 16'd6));
        check("step_at_closed", 32'(at_closed), 32'(e.pos == 16'd0));
        check("step_cycle", 32'(cyc), 32'(e.cyc));
      end
      prev_coil = coil;
      prev_pos  = pos;
    end
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_coil", 32'(coil), 32'h0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_at_open", 32'(at_open), 32'd0);
    check("rst_at_closed", 32'(at_closed), 32'd1);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);

    // Run forward from 0 to the open limit.
    c = cyc;
    bus = 4'b1000;
    push(4'b0100, 16'd1, c + 5);
    push(4'b0010, 16'd2, c + 9);
    push(4'b0001, 16'd3, c + 13);
    push(4'b1000, 16'd4, c + 17);
    push(4'b0100, 16'd5, c + 21);
    push(4'b0010, 16'd6, c + 25);
    at(c + 28);
    check("open_busy", 32'(busy), 32'd0);
    check("open_coil_hold", 32'(coil), 32'b0010);
    check("open_at_open", 32'(at_open), 32'd1);
    bus = 4'b0000;
    at(c + 30);

    // Reverse to 3, reverse-to-forward through DEAD, then forward-to-reverse.
    c = cyc;
    bus = 4'b0001;
    push(4'b0100, 16'd5, c + 5);
    push(4'b1000, 16'd4, c + 9);
    push(4'b0001, 16'd3, c + 13);
    at(c + 14);
    bus = 4'b1000;
    push(4'b1000, 16'd4, c + 25);
    at(c + 19);
    check("dead_busy", 32'(busy), 32'd1);
    check("dead_coil_held", 32'(coil), 32'b0001);
    at(c + 26);
    bus = 4'b0001;
    push(4'b0001, 16'd3, c + 37);
    push(4'b0010, 16'd2, c + 41);
    push(4'b0100, 16'd1, c + 45);
    push(4'b1000, 16'd0, c + 49);
    at(c + 52);
    check("closed_busy", 32'(busy), 32'd0);
    check("closed_at_closed", 32'(at_closed), 32'd1);
    bus = 4'b0000;

    // At the closed limit, reverse run and reverse jog are refused.
    at(c + 54);
    c = cyc;
    bus = 4'b0001;
    at(c + 10);
    check("limit_run_busy", 32'(busy), 32'd0);
    check("limit_run_coil", 32'(coil), 32'b1000);
    bus = 4'b0000;
    at(c + 12);
    bus = 4'b0010;
    at(c + 22);
    check("limit_jog_busy", 32'(busy), 32'd0);
    check("limit_jog_pos", 32'(pos), 32'd0);
    bus = 4'b0000;
    at(c + 24);

    // Held jog gives one step; a fresh pulse gives another.
    c = cyc;
    bus = 4'b0100;
    push(4'b0100, 16'd1, c + 5);
    at(c + 20);
    check("jog_held_busy", 32'(busy), 32'd0);
    bus = 4'b0000;
    at(c + 22);
    bus = 4'b0100;
    push(4'b0010, 16'd2, c + 27);
    at(c + 23);
    bus = 4'b0000;
    at(c + 30);

    // Illegal code in IDLE, then during a forward run.
    c = cyc;
    bus = 4'b1100;
    at(c + 1);
    check("illegal_idle_err", 32'(cmd_err), 32'd1);
    bus = 4'b0000;
    at(c + 2);
    check("illegal_idle_err_clr", 32'(cmd_err), 32'd0);
    check("illegal_idle_busy", 32'(busy), 32'd0);
    at(c + 4);
    c = cyc;
    bus = 4'b1000;
    push(4'b0001, 16'd3, c + 5);
    at(c + 6);
    bus = 4'b1100;
    at(c + 7);
    check("illegal_run_err", 32'(cmd_err), 32'd1);
    at(c + 8);
    check("illegal_run_busy_pre", 32'(busy), 32'd1);
    at(c + 10);
    check("illegal_run_busy_post", 32'(busy), 32'd0);
    bus = 4'b0000;
    at(c + 14);

    // Reset during a run at pos 4.
    c = cyc;
    bus = 4'b1000;
    push(4'b1000, 16'd4, c + 5);
    at(c + 7);
    rst = 1'b1;
    at(c + 8);
    check("midrst_coil", 32'(coil), 32'h0);
    check("midrst_pos", 32'(pos), 32'd0);
    check("midrst_at_closed", 32'(at_closed), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    at(c + 10);
    check("midrst_busy_held", 32'(busy), 32'd0);
    rst = 1'b0;
    bus = 4'b0000;
    at(c + 14);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_pos", 32'(pos), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/step_driver.md
# step_driver

Stepper-motor phase driver for the curtain: the consumer end of the 4-bit `bus` command produced by the light-comparison controller. It decodes the one-hot direction/jog command, paces steps with a programmable step timer, sequences the 4-phase full-step coil pattern, enforces a dead step on direction reversal, and tracks curtain position between the closed (0) and open (POS_MAX) limits.

## Interface
Parameters:
- STEP_DIV, 50000: clk cycles per step period; legal range ≥ 2.
- POS_MAX, 2000: step count from fully closed to fully open.
- HOLD, 1: 1 keeps the last coil pattern energized in IDLE; 0 drives 0000.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bus  in  4  command: 1000 run forward (open), 0001 run reverse (close), 0100 jog forward one step, 0010 jog reverse one step, 0000 stop; any other value is illegal.
- coil  out  4  motor phase outputs, registered.
- pos  out  16  current position in steps, 0..POS_MAX.
- busy  out  1  1 while in any state other than IDLE.
- at_open  out  1  pos == POS_MAX.
- at_closed  out  1  pos == 0.
- cmd_err  out  1  one-cycle pulse on the cycle an illegal `bus` value is sampled.

## Operation
- Phase table, index 0..3: 1000, 0100, 0010, 0001. Forward step: idx+1 mod 4. Reverse step: idx-1 mod 4 (0 → 3). Each step updates coil and pos on the same clock edge.
- States: IDLE, RUN_FWD, RUN_REV, JOG, DEAD.
- IDLE: bus=1000 and !at_open → RUN_FWD; bus=0001 and !at_closed → RUN_REV; jog code with rising qualification (previous sampled bus was 0000) and not at the limit in that direction → JOG. Timer cleared on every entry into IDLE.
- RUN_FWD/RUN_REV: step on every timer tick. Exit to IDLE on the tick where bus=0000, the command is illegal, or a step would pass a limit. The step that lands on a limit is taken; no further steps occur in that direction.
- Reversal (RUN_FWD sees 0001, or RUN_REV sees 1000): on the next tick, no step is taken → DEAD; DEAD lasts one full step period with coil held, then goes to the new RUN state if still commanded, otherwise to IDLE.
- JOG: exactly one step at the first tick, then IDLE. A jog code that stays asserted does not repeat; bus must return to 0000 before the next jog.
- Illegal bus: pulses cmd_err and is treated as 0000.
- Position arithmetic: 16-bit unsigned, saturating at 0 and POS_MAX; a step is never issued past either limit, so no wrap occurs.
- Coil in IDLE: last pattern if HOLD=1, else 0000. Coil is never multi-hot.

## Timing
- Reset: coil=0000, phase idx=0, pos=0, busy=0, at_open=0, at_closed=1, cmd_err=0, state IDLE, timer=0. Reset mid-step aborts immediately; no partial step.
- bus is sampled every clk; it is asynchronous to this block's pacing and is treated as level-valid.
- IDLE → RUN/JOG transition happens on the edge after the qualifying bus sample. busy rises on that edge.
- Timer counts 0..STEP_DIV-1 from entry into RUN/JOG/DEAD; a tick occurs when it wraps. The first step therefore lands STEP_DIV cycles after entry, and subsequent steps every STEP_DIV cycles.
- Stop latency: up to STEP_DIV cycles (evaluated at the next tick). No step is taken on the stop tick.
- at_open/at_closed are registered and update on the same edge as pos.
- The stop/reversal decision uses bus sampled on the tick cycle.

## Structure
- Package step_pkg: phase-pattern constants, the five command encodings, and the state enum.
- Sub-module step_timer: a prescaler with clear and enable inputs and a one-cycle tick output (STEP_DIV parameter). Phase sequencing, the FSM, and the position counter stay in step_driver.

## Test plan
(All scenarios use STEP_DIV=4, POS_MAX=6, HOLD=1.)
- Reset, then bus=1000 held → coil steps 0100, 0010, 0001, 1000, 0100, 0010 every 4 clk, first step 4 clk after entry; pos reaches 6, at_open=1, then IDLE with coil held at 0010.
- From pos=3 running forward, switch bus to 0001 → the next tick takes no step (DEAD), one step period passes with coil unchanged, then reverse steps begin; pos goes 3, 2, 1, 0; at_closed=1.
- bus=0100 held for 20 clk → exactly one forward step (pos 0→1); release to 0000, pulse 0100 again → pos=2.
- bus=1100 for one cycle in IDLE → cmd_err pulses once, no step, busy stays 0; during RUN_FWD → exit to IDLE on the next tick.
- At pos=0, bus=0001 or 0010 → stays IDLE, coil unchanged, busy=0.
- rst asserted mid-run at pos=4 → next edge coil=0000, pos=0, at_closed=1, state IDLE regardless of bus.
